// File: rtl/safe_pkg.sv
// Shared definitions for the safe controller and its lockout supervisor:
// status codes, key bit positions and the lockout state encoding.
package safe_pkg;

  typedef enum logic [2:0] {
    IN_LOCK   = 3'd0,
    IN_CHECK  = 3'd1,
    IN_OPEN   = 3'd2,
    PASS_OK   = 3'd3,
    PASS_FAIL = 3'd4,
    TIMEOUT   = 3'd5,
    CLOSE     = 3'd6
  } data_out_t;

  localparam int NUM_KEYS      = 6;
  localparam int KEY_0_IDX     = 0;
  localparam int KEY_1_IDX     = 1;
  localparam int KEY_2_IDX     = 2;
  localparam int KEY_3_IDX     = 3;
  localparam int KEY_OK_IDX    = 4;
  localparam int KEY_CLEAR_IDX = 5;

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_LOCKOUT = 2'd1,
    ST_RELEASE = 2'd2
  } lock_state_t;

  // A code entry counts against the user whether it was wrong or abandoned.
  function automatic logic is_fail_evt(input logic [2:0] code);
    return (code == PASS_FAIL) || (code == TIMEOUT);
  endfunction

endpackage

// File: rtl/safe_lockout_ctrl_key_pulse_gen.sv
// Rising-edge detector for raw key levels; emits a registered one-cycle
// pulse per press, suppressed while enable is low.
module key_pulse_gen #(
  parameter int WIDTH = 6
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             enable,
  input  logic [WIDTH-1:0] keys,
  output logic [WIDTH-1:0] pulses
);

  logic [WIDTH-1:0] hist_reg;
  logic [WIDTH-1:0] pulse_reg;
  logic [WIDTH-1:0] pulse_next;

  // History keeps tracking even when disabled, so keys held across a
  // blocked window never produce a late pulse.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_edge
      assign pulse_next[gi] = enable & keys[gi] & ~hist_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      hist_reg  <= '0;
      pulse_reg <= '0;
    end else begin
      hist_reg  <= keys;
      pulse_reg <= pulse_next;
    end
  end

  assign pulses = pulse_reg;

endmodule

// File: rtl/safe_lockout_ctrl.sv
// Keypad supervisor: forwards key presses as pulses and imposes an
// exponentially growing lockout after repeated failed code entries.
module safe_lockout_ctrl
  import safe_pkg::*;
#(
  parameter int WRONG_ATTEMPTS = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int MAX_BACKOFF    = 3
) (
  input  logic                                  clk_i,
  input  logic                                  arst_n_i,
  input  logic [5:0]                            keys_i,
  input  logic                                  door_sealed_i,
  input  logic [2:0]                            evt_i,
  input  logic                                  evt_valid_i,
  output logic [5:0]                            keys_o,
  output logic                                  door_sealed_o,
  output logic                                  lockout_o,
  output logic [$clog2(WRONG_ATTEMPTS+1)-1:0]   attempts_o,
  output logic [$clog2(MAX_BACKOFF+1)-1:0]      backoff_o
);

  localparam int AW = $clog2(WRONG_ATTEMPTS + 1);
  localparam int BW = $clog2(MAX_BACKOFF + 1);
  localparam int CW = $clog2((LOCKOUT_CYCLES << MAX_BACKOFF) + 1);

  lock_state_t   state_reg, state_next;
  logic [AW-1:0] attempts_reg, attempts_next;
  logic [BW-1:0] backoff_reg, backoff_next;
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] base_len;
  logic          keys_enable;

  assign base_len = CW'(LOCKOUT_CYCLES);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_reg    <= ST_ARMED;
      attempts_reg <= '0;
      backoff_reg  <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      attempts_reg <= attempts_next;
      backoff_reg  <= backoff_next;
      count_reg    <= count_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    attempts_next = attempts_reg;
    backoff_next  = backoff_reg;
    count_next    = count_reg;
    case (state_reg)
      ST_ARMED: begin
        if (evt_valid_i) begin
          if (is_fail_evt(evt_i)) begin
            if (attempts_reg == AW'(WRONG_ATTEMPTS - 1)) begin
              // Duration uses the backoff in force before this lockout.
              state_next    = ST_LOCKOUT;
              attempts_next = '0;
              count_next    = base_len << backoff_reg;
              if (backoff_reg != BW'(MAX_BACKOFF))
                backoff_next = backoff_reg + BW'(1);
            end else begin
              attempts_next = attempts_reg + AW'(1);
            end
          end else if (evt_i == PASS_OK) begin
            attempts_next = '0;
            backoff_next  = '0;
          end
        end
      end
      ST_LOCKOUT: begin
        count_next = count_reg - CW'(1);
        if (count_reg == CW'(1))
          state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (keys_i == '0)
          state_next = ST_ARMED;
      end
      default: state_next = ST_ARMED;
    endcase
  end

  always_comb begin
    keys_enable = (state_reg == ST_ARMED);
    lockout_o   = (state_reg != ST_ARMED);
    attempts_o  = attempts_reg;
    backoff_o   = backoff_reg;
  end

  assign door_sealed_o = door_sealed_i;

  key_pulse_gen #(
    .WIDTH (NUM_KEYS)
  ) u_key_pulse_gen (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .enable   (keys_enable),
    .keys     (keys_i),
    .pulses   (keys_o)
  );

endmodule
